wishbone_sram_slave: RTL and testbench

Wishbone classic single-beat responder that turns CPU bus transactions into timed asynchronous-SRAM cycles. Sits behind the CPU's Wishbone master/MMU path, one instance per SRAM bank (base RAM, ext RAM). Adds programmable read and write wait states, byte-lane writes and a single-cycle ack.

---
 rtl/wishbone_sram_slave.sv | 211 +++++++++++++++++++++
 tb/tb_wishbone_sram_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_sram_slave.sv
// wishbone_sram_slave
//   Wishbone classic single-beat responder driving one asynchronous SRAM bank.
//   It adds programmable read/write wait states, byte-lane writes and a
//   single-cycle ack. Every output is registered.
//
//   Optional build macro: WB_ERR_EN
//     defined   - an accept whose upper address bits are non-zero is answered
//                 with a one-cycle wb_err_o pulse, and the SRAM is not touched
//     undefined - upper address bits are ignored (aliasing); wb_err_o stays 0
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     wb_cyc_i, wb_stb_i  request qualifiers, sampled only in IDLE
//     wb_we_i, wb_sel_i   direction and byte lanes
//     wb_adr_i, wb_dat_i  byte address and write data
//     wb_dat_o            read data, held between reads
//     wb_ack_o, wb_err_o  one-cycle completion pulses
//     sram_*              SRAM address/data/strobes; sram_dq_oe drives the pad tristate
module wishbone_sram_slave #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_dq_o,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    // A wait count of zero behaves like one.
    localparam int unsigned RdWait = (READ_WAIT == 0) ? 1 : READ_WAIT;
    localparam int unsigned WrWait = (WRITE_WAIT == 0) ? 1 : WRITE_WAIT;
    localparam logic [3:0]  RdLoad = 4'(RdWait - 1);
    localparam logic [3:0]  WrLoad = 4'(WrWait - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone,
        StErr
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        dat_q, dat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        dq_q, dq_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic [3:0]         be_n_q, be_n_d;

    logic               addr_bad;
    logic               unused_adr;

`ifdef WB_ERR_EN
    assign addr_bad   = |wb_adr_i[31:ADDR_W+2];
    assign unused_adr = ^wb_adr_i[1:0];
`else
    // Upper bits alias into the bank.
    assign addr_bad   = 1'b0;
    assign unused_adr = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        dq_oe_d = dq_oe_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        be_n_d  = be_n_q;

        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (addr_bad) begin
                        state_d = StErr;
                    end else begin
                        addr_d = wb_adr_i[ADDR_W+1:2];
                        dq_d   = wb_dat_i;
                        ce_n_d = 1'b0;
                        if (!wb_we_i) begin
                            // Reads always fetch the full word.
                            oe_n_d  = 1'b0;
                            be_n_d  = 4'b0000;
                            cnt_d   = RdLoad;
                            state_d = StRd;
                        end else begin
                            be_n_d  = ~wb_sel_i;
                            dq_oe_d = 1'b1;
                            oe_n_d  = 1'b1;
                            state_d = StWrSetup;
                        end
                    end
                end
            end
            StRd: begin
                if (cnt_q == 4'd0) begin
                    dat_d   = sram_dq_i;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = 4'b1111;
                    ack_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrSetup: begin
                // No lanes selected: run the cycle but never strobe we_n.
                we_n_d  = (be_n_q == 4'b1111);
                cnt_d   = WrLoad;
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == 4'd0) begin
                    we_n_d  = 1'b1;
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrHold: begin
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                be_n_d  = 4'b1111;
                ack_d   = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                err_d   = 1'b1;
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'd0;
            addr_q  <= '0;
            dq_q    <= 32'd0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 4'b1111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign sram_addr_o = addr_q;
    assign sram_dq_o   = dq_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// tb_wishbone_sram_slave
//   Directed bench for wishbone_sram_slave (ADDR_W=20, READ_WAIT=2, WRITE_WAIT=2).
//   Each request pushes its expected completion into a scoreboard queue; a
//   separate monitor pops and compares on every ack/err pulse.
module tb_wishbone_sram_slave;

    localparam int unsigned AW = 20;
    localparam int unsigned RW = 2;
    localparam int unsigned WW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic          wb_we_i = 1'b0;
    logic [3:0]    wb_sel_i = 4'h0;
    logic [31:0]   wb_adr_i = 32'h0;
    logic [31:0]   wb_dat_i = 32'h0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_dq_o;
    logic [31:0]   sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    wishbone_sram_slave #(
        .ADDR_W    (AW),
        .READ_WAIT (RW),
        .WRITE_WAIT(WW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .sram_addr_o(sram_addr_o),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n)
    );

    always #5 clk = ~clk;

    // SRAM model: 256 words, indexed by the low address byte.
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;

    assign sram_dq_i = mem[sram_addr_o[7:0]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_resp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct packed {
        logic        is_err;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    logic prev_resp = 1'b0;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (wb_ack_o || wb_err_o) begin
            n_resp++;
            if (prev_resp) begin
                n_total++;
                $display("FAIL sb_pulse: response high two cycles in a row, required single-cycle");
            end
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: ack=%b err=%b with no pending request, required none",
                         wb_ack_o, wb_err_o);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_err", {31'b0, wb_err_o}, {31'b0, sb_e.is_err});
                check("sb_ack", {31'b0, wb_ack_o}, {31'b0, ~sb_e.is_err});
                check("sb_dat", wb_dat_o, sb_e.dat);
            end
        end
        prev_resp <= wb_ack_o || wb_err_o;
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // One transaction; called at a negedge with the DUT idle. Inputs are scrambled
    // right after the accept edge to show they are ignored.
    task automatic xfer(input string name, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [AW-1:0] exp_addr, input logic [3:0] exp_be_n,
                        input int exp_lat, input int exp_ce, input int exp_oe,
                        input int exp_we, input logic exp_err, input logic [31:0] exp_dat);
        int k = 0;
        int ce_low = 0;
        int oe_low = 0;
        int we_low = 0;
        bit done = 0;
        bit addr_ok = 1;
        bit be_ok = 1;
        sb_q.push_back('{is_err: exp_err, dat: exp_dat});
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_adr_i = adr;
        wb_dat_i = dat;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
                wb_we_i  = ~we;
                wb_sel_i = ~sel;
                wb_adr_i = $urandom;
                wb_dat_i = $urandom;
            end
            if (!sram_ce_n) begin
                ce_low++;
                if (sram_addr_o !== exp_addr) addr_ok = 0;
                if (sram_be_n !== exp_be_n) be_ok = 0;
            end
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (wb_ack_o || wb_err_o) done = 1;
        end
        check({name, "_lat"}, 32'(k), 32'(exp_lat));
        check({name, "_ce_low"}, 32'(ce_low), 32'(exp_ce));
        check({name, "_oe_low"}, 32'(oe_low), 32'(exp_oe));
        check({name, "_we_low"}, 32'(we_low), 32'(exp_we));
        if (exp_ce != 0) begin
            check({name, "_addr_ok"}, {31'b0, addr_ok}, 32'd1);
            check({name, "_be_ok"}, {31'b0, be_ok}, 32'd1);
        end
        @(negedge clk);  // DONE cycle
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int t;
    int gap;
    int resp_snap;

    initial begin
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h11, 32'h12345678);
        preload(8'h00, 32'hCAFEF00D);
        preload(8'hFF, 32'h0BADC0DE);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_be_n", {28'b0, sram_be_n}, 32'hF);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("rst_dat_o", wb_dat_o, 32'd0);

        // Read word 0x10: ce/oe low RW cycles, ack RW+1 edges counting the accept edge.
        xfer("rd40", 1'b0, 4'hF, 32'h0000_0040, 32'h0, 20'h00010, 4'b0000,
             RW + 1, RW, RW, 0, 1'b0, 32'hDEADBEEF);
        // Byte-lane 2 write: setup + WW pulse + hold with ce low, ack at WW+3.
        xfer("wrb44", 1'b1, 4'b0100, 32'h0000_0044, 32'h00AB_0000, 20'h00011, 4'b1011,
             WW + 3, WW + 2, 0, WW, 1'b0, 32'hDEADBEEF);
        xfer("rd44", 1'b0, 4'hF, 32'h0000_0044, 32'h0, 20'h00011, 4'b0000,
             RW + 1, RW, RW, 0, 1'b0, 32'h12AB5678);
        // Zero-sel write: we_n never strobes, memory unchanged.
        xfer("wr0sel", 1'b1, 4'b0000, 32'h0000_0044, 32'hFFFF_FFFF, 20'h00011, 4'b1111,
             WW + 3, WW + 2, 0, 0, 1'b0, 32'h12AB5678);
        xfer("rd44b", 1'b0, 4'hF, 32'h0000_0044, 32'h0, 20'h00011, 4'b0000,
             RW + 1, RW, RW, 0, 1'b0, 32'h12AB5678);
        xfer("wrf80", 1'b1, 4'hF, 32'h0000_0080, 32'hA5A5_5A5A, 20'h00020, 4'b0000,
             WW + 3, WW + 2, 0, WW, 1'b0, 32'h12AB5678);
        xfer("rd80", 1'b0, 4'hF, 32'h0000_0080, 32'h0, 20'h00020, 4'b0000,
             RW + 1, RW, RW, 0, 1'b0, 32'hA5A55A5A);
        // Last word of the bank.
        xfer("rdlast", 1'b0, 4'hF, 32'h003F_FFFC, 32'h0, 20'hFFFFF, 4'b0000,
             RW + 1, RW, RW, 0, 1'b0, 32'h0BADC0DE);
`ifdef WB_ERR_EN
        // Out of range: err on the edge after accept, SRAM untouched, dat_o held.
        xfer("err", 1'b0, 4'hF, 32'h0040_0000, 32'h0, 20'h00000, 4'b0000,
             2, 0, 0, 0, 1'b1, 32'h0BADC0DE);
`else
        // Out of range aliases to word 0.
        xfer("alias", 1'b0, 4'hF, 32'h0040_0000, 32'h0, 20'h00000, 4'b0000,
             RW + 1, RW, RW, 0, 1'b0, 32'hCAFEF00D);
`endif

        // Back-to-back reads with stb held through both acks.
        @(negedge clk);
        #1;
        resp_snap = n_resp;
        sb_q.push_back('{is_err: 1'b0, dat: 32'hDEADBEEF});
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hF;
        wb_adr_i = 32'h0000_0040;
        t = 0;
        while (!wb_ack_o && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_lat", 32'(t), 32'(RW + 1));
        sb_q.push_back('{is_err: 1'b0, dat: 32'h12AB5678});
        wb_adr_i = 32'h0000_0044;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 2) begin
                // Second request already accepted; these changes must be ignored.
                wb_adr_i = 32'h0000_0080;
                wb_we_i  = 1'b1;
            end
        end while (!wb_ack_o && gap < 60);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        // DONE cycle, IDLE accept, then RW read edges.
        check("b2b_gap", 32'(gap), 32'(RW + 2));
        repeat (4) @(negedge clk);
        #1;
        check("b2b_resp_count", 32'(n_resp - resp_snap), 32'd2);

        // Reset two cycles into a write: SRAM released at once, no ack ever.
        @(negedge clk);
        resp_snap = n_resp;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_sel_i = 4'hF;
        wb_adr_i = 32'h0000_00C0;
        wb_dat_i = 32'h1111_1111;
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk);
        check("rstw_we_low_before", {31'b0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rstw_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("rstw_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("rstw_be_n", {28'b0, sram_be_n}, 32'hF);
        check("rstw_dat_o", wb_dat_o, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rstw_no_ack", 32'(n_resp - resp_snap), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
